// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM request arbiter.
// Arbiter state encoding, default widths and the index-width helper.
package bram_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arbState_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_NUM_REQ    = 4;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_grant.sv
// Round-robin one-hot grant: searches upward from the requester after last_grant, wrapping.
// Purely combinational, zero latency; grant is all-zero when request is all-zero.
module round_robin_grant
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]           request,
  input  logic [idxWidth(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]           grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && request[i] && ((int'(last_grant) + off) % NUM_REQ == i)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram_request_arbiter.sv
// N-to-1 BRAM port arbiter: one transfer per cycle, response one cycle later; losers stall on req_ready=0.
// Optional hold-grant locking is built only when BRAM_ARB_LOCK_EN is defined.
module bram_request_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ-1:0]                req_lock,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_byte_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              readEnable,
  output logic                              writeEnable,
  output logic [DATA_WIDTH/8-1:0]           writeByteEnable,
  output logic [ADDR_WIDTH-1:0]             address,
  output logic [DATA_WIDTH-1:0]             writeData,
  input  logic [DATA_WIDTH-1:0]             readData
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = idxWidth(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]      lastGrant;
  logic [NUM_REQ-1:0]    rrGrant;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    respValidQ;
  logic [IDX_W-1:0]      grantIdx;
  logic                  transfer;
  logic                  grantWrite;
  logic [BE_W-1:0]       grantByteEn;
  logic [ADDR_WIDTH-1:0] grantAddr;
  logic [DATA_WIDTH-1:0] grantWdata;

  round_robin_grant #(
    .NUM_REQ(NUM_REQ)
  ) rrGrantInst (
    .request   (req_valid),
    .last_grant(lastGrant),
    .grant     (rrGrant)
  );

`ifdef BRAM_ARB_LOCK_EN
  arbState_e          state;
  logic [IDX_W-1:0]   lockOwner;
  logic [NUM_REQ-1:0] ownerMask;
  logic               ownerValid;
  logic               grantLock;

  always_comb begin
    ownerMask  = '0;
    ownerValid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lockOwner == IDX_W'(i)) begin
        ownerMask[i] = 1'b1;
        ownerValid   = req_valid[i];
      end
    end
  end

  // Reset gates the grant combinationally so nothing reaches the BRAM while held in reset.
  always_comb begin
    if (!reset) begin
      grant = '0;
    end else if (state == LOCKED) begin
      grant = ownerValid ? ownerMask : '0;
    end else begin
      grant = rrGrant;
    end
  end

  assign grantLock = |(grant & req_lock);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      lockOwner <= '0;
    end else begin
      case (state)
        ARB: begin
          if (transfer && grantLock) begin
            state     <= LOCKED;
            lockOwner <= grantIdx;
          end
        end
        LOCKED: begin
          if (!ownerValid || (transfer && !grantLock)) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
`else
  logic unusedLock;
  assign unusedLock = ^req_lock;
  assign grant      = reset ? rrGrant : '0;
`endif

  always_comb begin
    grantIdx    = '0;
    grantWrite  = 1'b0;
    grantByteEn = '0;
    grantAddr   = '0;
    grantWdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantIdx    = IDX_W'(i);
        grantWrite  = req_write[i];
        grantByteEn = req_byte_en[i*BE_W +: BE_W];
        grantAddr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        grantWdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign transfer        = |grant;
  assign req_ready       = grant;
  assign readEnable      = transfer;
  assign writeEnable     = grantWrite;
  assign writeByteEnable = grantByteEn;
  assign address         = grantAddr;
  assign writeData       = grantWdata;

  // The BRAM always reads (write-first), so the response slot mirrors the previous cycle's grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lastGrant  <= LAST_IDX;
      respValidQ <= '0;
    end else begin
      respValidQ <= grant;
      if (transfer) begin
        lastGrant <= grantIdx;
      end
    end
  end

  assign resp_valid = respValidQ;
  assign resp_rdata = (|respValidQ) ? readData : '0;

endmodule
